snapshot_mem_responder: RTL

- Memory-side responder for the snapshot register front-end.
- Accepts single-beat read/write requests on the mem_* handshake and returns a one-cycle mem_ack_vld.
- Drives a single-port SRAM macro with a configurable read latency.
- Sits between the register-block snapshot logic and the entry-table SRAM. It registers the command, sequences the SRAM access and holds read data stable for the initiator's delayed capture.

---
 rtl/snapshot_mem_responder_if.sv | 25 ++
 rtl/snapshot_mem_responder.sv | 117 +++++++++++
 2 files changed

// File: rtl/snapshot_mem_responder_if.sv
// Request/ack handshake between the snapshot register front-end (master)
// and the entry-table memory responder (slave).
interface snapshot_mem_responder_if #(
  parameter int MEM_WIDTH   = 36,
  parameter int ENTRY_WIDTH = 7
);
  logic                   mem_req_vld;
  logic [ENTRY_WIDTH-1:0] mem_addr;
  logic                   mem_rd_en;
  logic                   mem_wr_en;
  logic [MEM_WIDTH-1:0]   mem_wr_data;
  logic [MEM_WIDTH-1:0]   mem_rd_data;
  logic                   mem_ack_vld;
  logic                   mem_err;

  modport master (
    output mem_req_vld, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
    input  mem_rd_data, mem_ack_vld, mem_err
  );

  modport slave (
    input  mem_req_vld, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
    output mem_rd_data, mem_ack_vld, mem_err
  );
endinterface

// File: rtl/snapshot_mem_responder.sv
// Memory-side responder: registers one request, sequences a single-port SRAM
// access with fixed read latency, and returns a one-cycle ack with held read data.
module snapshot_mem_responder #(
  parameter int                  MEM_WIDTH   = 36,
  parameter int                  ENTRY_WIDTH = 7,
  parameter int                  DEPTH       = 128,
  parameter int                  RD_LATENCY  = 1,
  parameter logic [MEM_WIDTH-1:0] RST_VALUE  = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  snapshot_mem_responder_if.slave mem,
  output logic                   sram_ce,
  output logic                   sram_we,
  output logic [ENTRY_WIDTH-1:0] sram_addr,
  output logic [MEM_WIDTH-1:0]   sram_wdata,
  input  logic [MEM_WIDTH-1:0]   sram_rdata
);

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    ISSUE   = 4'b0010,
    RD_WAIT = 4'b0100,
    ACK     = 4'b1000
  } state_t;

  localparam logic [ENTRY_WIDTH:0] DEPTH_LIM = (ENTRY_WIDTH+1)'(DEPTH);

  state_t     state;
  logic       cmd_rd;
  logic       cmd_wr;
  logic       cmd_oor;
  logic [1:0] lat_cnt;
  logic       req_in_range;

  assign req_in_range = {1'b0, mem.mem_addr} < DEPTH_LIM;

  // SRAM strobes are launched from the IDLE capture edge so they are visible
  // in the ISSUE cycle itself; the command registers steer ISSUE's decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cmd_rd          <= 1'b0;
      cmd_wr          <= 1'b0;
      cmd_oor         <= 1'b0;
      lat_cnt         <= 2'd0;
      sram_ce         <= 1'b0;
      sram_we         <= 1'b0;
      sram_addr       <= '0;
      sram_wdata      <= '0;
      mem.mem_rd_data <= RST_VALUE;
      mem.mem_ack_vld <= 1'b0;
      mem.mem_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem.mem_req_vld) begin
            cmd_rd  <= mem.mem_rd_en;
            cmd_wr  <= mem.mem_wr_en;
            cmd_oor <= !req_in_range;
            if (req_in_range && (mem.mem_rd_en || mem.mem_wr_en)) begin
              sram_ce   <= 1'b1;
              sram_we   <= mem.mem_wr_en;
              sram_addr <= mem.mem_addr;
              if (mem.mem_wr_en) begin
                sram_wdata <= mem.mem_wr_data;
              end
            end
            state <= ISSUE;
          end
        end

        ISSUE: begin
          sram_ce <= 1'b0;
          sram_we <= 1'b0;
          if (cmd_rd && !cmd_wr && !cmd_oor) begin
            lat_cnt <= 2'(RD_LATENCY - 1);
            state   <= RD_WAIT;
          end else begin
            mem.mem_ack_vld <= 1'b1;
            mem.mem_err     <= (cmd_oor && (cmd_rd || cmd_wr)) || (cmd_rd && cmd_wr);
            if (cmd_oor && cmd_rd && !cmd_wr) begin
              mem.mem_rd_data <= RST_VALUE;
            end
            state <= ACK;
          end
        end

        // Counter reaches zero in the cycle the SRAM output is valid.
        RD_WAIT: begin
          if (lat_cnt == 2'd0) begin
            mem.mem_rd_data <= sram_rdata;
            mem.mem_ack_vld <= 1'b1;
            state           <= ACK;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end

        ACK: begin
          mem.mem_ack_vld <= 1'b0;
          mem.mem_err     <= 1'b0;
          state           <= IDLE;
        end

        default: begin
          sram_ce         <= 1'b0;
          sram_we         <= 1'b0;
          mem.mem_ack_vld <= 1'b0;
          mem.mem_err     <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule
